test_vector_sequencer: RTL and testbench

//  Synthesizable stimulus engine for on-board CPU bring-up. Holds a table of

---
 rtl/test_vector_sequencer_if.sv | 36 +++
 rtl/test_vector_sequencer.sv | 155 +++++++++++++++
 tb/tb_test_vector_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_vector_sequencer_if.sv
// Bus between the vector sequencer and its host: table writes, run control,
// and the vector/status outputs that drive the CPU under bring-up.
interface test_vector_sequencer_if #(
  parameter int SW_W  = 4,
  parameter int PB_W  = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int CYC_W = 24
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + SW_W + PB_W + CNT_W;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [EW-1:0]    wr_data;
  logic             start;
  logic             abort;
  logic             loop_en;
  logic             DUT_Resetn;
  logic [SW_W-1:0]  SW_out;
  logic [PB_W-1:0]  PB_out;
  logic             busy;
  logic             done;
  logic [AW-1:0]    entry_idx;
  logic [CYC_W-1:0] cyc_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, start, abort, loop_en,
    input  DUT_Resetn, SW_out, PB_out, busy, done, entry_idx, cyc_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, abort, loop_en,
    output DUT_Resetn, SW_out, PB_out, busy, done, entry_idx, cyc_cnt
  );
endinterface

// File: rtl/test_vector_sequencer.sv
// Table-driven stimulus engine: plays {rstn, sw, pb, count} vectors into the
// CPU pins, each held for exactly its count of cycles, with loop and abort.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | CPU held in reset, vectors zero, waiting for start
//  RUN    | applying table entries back-to-back
//  DONE   | sequence finished, last vector held, waiting for start/abort
module test_vector_sequencer #(
  parameter int SW_W  = 4,
  parameter int PB_W  = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int CYC_W = 24
) (
  input  logic                  Clock,
  input  logic                  Reset,
  test_vector_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic            rstn;
    logic [SW_W-1:0] sw;
    logic [PB_W-1:0] pb;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t           tbl_q [DEPTH];
  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             rstn_q, rstn_d;
  logic [SW_W-1:0]  sw_q, sw_d;
  logic [PB_W-1:0]  pb_q, pb_d;
  logic             done_q, done_d;

  entry_t           ent0, ent_nxt, ld;
  logic [AW-1:0]    idx_nxt;
  logic             last_entry;
  logic [CYC_W-1:0] cyc_inc;
  logic             load_first, load_next;

  assign ent0       = tbl_q[0];
  assign idx_nxt    = idx_q + AW'(1);
  assign ent_nxt    = tbl_q[idx_nxt];
  assign last_entry = (idx_q == AW'(DEPTH - 1)) || (ent_nxt.cnt == '0);
  assign cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
  assign ld         = load_first ? ent0 : ent_nxt;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    remain_d   = remain_q;
    cyc_d      = cyc_q;
    rstn_d     = rstn_q;
    sw_d       = sw_q;
    pb_d       = pb_q;
    done_d     = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;

    if (bus.abort) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      remain_d = '0;
      cyc_d    = '0;
      rstn_d   = 1'b0;
      sw_d     = '0;
      pb_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (ent0.cnt != '0) begin
              load_first = 1'b1;
              cyc_d      = CYC_W'(1);
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (remain_q != '0) begin
            remain_d = remain_q - CNT_W'(1);
            cyc_d    = cyc_inc;
          end else if (!last_entry) begin
            load_next = 1'b1;
            cyc_d     = cyc_inc;
          end else if (bus.loop_en && (ent0.cnt != '0)) begin
            // entry 0 may have been rewritten to count 0 mid-run; that ends the loop
            load_first = 1'b1;
            cyc_d      = cyc_inc;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (load_first || load_next) begin
        state_d  = S_RUN;
        idx_d    = load_first ? '0 : idx_nxt;
        remain_d = ld.cnt - CNT_W'(1);
        rstn_d   = ld.rstn;
        sw_d     = ld.sw;
        pb_d     = ld.pb;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      remain_q <= '0;
      cyc_q    <= '0;
      rstn_q   <= 1'b0;
      sw_q     <= '0;
      pb_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      cyc_q    <= cyc_d;
      rstn_q   <= rstn_d;
      sw_q     <= sw_d;
      pb_q     <= pb_d;
      done_q   <= done_d;
    end
  end

  // A write on the same edge as a load lands after the read, so the old entry is applied.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (bus.wr_en) begin
      tbl_q[bus.wr_addr] <= entry_t'(bus.wr_data);
    end
  end

  assign bus.DUT_Resetn = rstn_q;
  assign bus.SW_out     = sw_q;
  assign bus.PB_out     = pb_q;
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = done_q;
  assign bus.entry_idx  = idx_q;
  assign bus.cyc_cnt    = cyc_q;
endmodule

// File: tb/tb_test_vector_sequencer.sv
// Bench for test_vector_sequencer: per-cycle expected output stream built
// from the vector table into a scoreboard queue and compared as the DUT runs.
module tb_test_vector_sequencer;
  localparam int SW_W  = 4;
  localparam int PB_W  = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int CYC_W = 24;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  test_vector_sequencer_if #(
    .SW_W(SW_W), .PB_W(PB_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .CYC_W(CYC_W)
  ) bus ();

  test_vector_sequencer #(
    .SW_W(SW_W), .PB_W(PB_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .CYC_W(CYC_W)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        rstn;
    logic [3:0]  sw;
    logic [3:0]  pb;
    logic [15:0] cnt;
  } vec_t;

  typedef struct packed {
    logic        rstn;
    logic [3:0]  sw;
    logic [3:0]  pb;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic [23:0] cyc;
  } obs_t;

  obs_t sb[$];
  vec_t tv[5];
  vec_t tbl_m[DEPTH];
  int   checks = 0;
  int   errors = 0;
  int   cyc_e  = 0;
  obs_t zero_o = '0;

  function automatic obs_t sample();
    obs_t o;
    o.rstn = bus.DUT_Resetn;
    o.sw   = bus.SW_out;
    o.pb   = bus.PB_out;
    o.idx  = bus.entry_idx;
    o.busy = bus.busy;
    o.done = bus.done;
    o.cyc  = bus.cyc_cnt;
    return o;
  endfunction

  function automatic obs_t mk(logic rstn, logic [3:0] sw, logic [3:0] pb, logic [3:0] idx,
                              logic busy, logic done, logic [23:0] cyc);
    obs_t o;
    o.rstn = rstn; o.sw = sw; o.pb = pb; o.idx = idx;
    o.busy = busy; o.done = done; o.cyc = cyc;
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual rstn=%b sw=%h pb=%h idx=%0d busy=%b done=%b cyc=%0d required rstn=%b sw=%h pb=%h idx=%0d busy=%b done=%b cyc=%0d",
               name, act.rstn, act.sw, act.pb, act.idx, act.busy, act.done, act.cyc,
               exp.rstn, exp.sw, exp.pb, exp.idx, exp.busy, exp.done, exp.cyc);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic write_entry(int a, vec_t v);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[3:0];
    bus.wr_data = {v.rstn, v.sw, v.pb, v.cnt};
    tbl_m[a]    = v;
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Expected RUN cycles for entries 0..n_ent-1 of the mirrored table, capped at limit records.
  task automatic push_pass(int n_ent, int limit);
    int pushed = 0;
    for (int e = 0; e < n_ent; e++) begin
      for (int c = 0; c < int'(tbl_m[e].cnt); c++) begin
        if (pushed >= limit) return;
        cyc_e++;
        sb.push_back(mk(tbl_m[e].rstn, tbl_m[e].sw, tbl_m[e].pb, e[3:0], 1'b1, 1'b0, cyc_e[23:0]));
        pushed++;
      end
    end
  endtask

  task automatic run_stream(string name, int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard underrun at record %0d", name, i);
        return;
      end
      e = sb.pop_front();
      check($sformatf("%s[%0d]", name, i), sample(), e);
      step();
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_abort(string name);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check(name, sample(), zero_o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1'b0, 4'h0, 4'h0, 16'd1};
    tv[1] = '{1'b1, 4'h5, 4'h1, 16'd30};
    tv[2] = '{1'b1, 4'h5, 4'h0, 16'd30};
    tv[3] = '{1'b1, 4'hA, 4'h1, 16'd30};
    tv[4] = '{1'b0, 4'h0, 4'h0, 16'd0};
    for (int i = 0; i < DEPTH; i++) tbl_m[i] = '{1'b0, 4'h0, 4'h0, 16'd0};

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.loop_en = 1'b0;

    // T1: reset
    Reset = 1'b1;
    step();
    step();
    check("t1_reset", sample(), zero_o);
    Reset = 1'b0;
    step();
    check("t1_idle", sample(), zero_o);

    // T2: single pass, then done pulse and hold
    for (int i = 0; i < 5; i++) write_entry(i, tv[i]);
    cyc_e = 0;
    push_pass(4, 1000);
    sb.push_back(mk(1'b1, 4'hA, 4'h1, 4'd3, 1'b0, 1'b1, 24'd91));
    sb.push_back(mk(1'b1, 4'hA, 4'h1, 4'd3, 1'b0, 1'b0, 24'd91));
    pulse_start();
    run_stream("t2", 93);
    check("t2_hold", sample(), mk(1'b1, 4'hA, 4'h1, 4'd3, 1'b0, 1'b0, 24'd91));

    // T3a: loop back to entry 0 with no gap and no done
    bus.loop_en = 1'b1;
    cyc_e = 0;
    push_pass(4, 1000);
    push_pass(4, 6);
    pulse_start();
    run_stream("t3a_loop", 97);
    do_abort("t3a_abort");

    // T3b/T3c: full table of count=1 entries, index wraps DEPTH-1 -> 0
    for (int i = 0; i < DEPTH; i++) begin
      vec_t v;
      v.rstn = 1'b1; v.sw = i[3:0]; v.pb = ~i[3:0]; v.cnt = 16'd1;
      write_entry(i, v);
    end
    cyc_e = 0;
    push_pass(DEPTH, 1000);
    push_pass(DEPTH, 3);
    pulse_start();
    run_stream("t3b_wrap_loop", 19);
    do_abort("t3b_abort");

    bus.loop_en = 1'b0;
    cyc_e = 0;
    push_pass(DEPTH, 1000);
    sb.push_back(mk(1'b1, 4'hF, 4'h0, 4'd15, 1'b0, 1'b1, 24'd16));
    pulse_start();
    run_stream("t3c_wrap_end", 17);
    do_abort("t3c_abort");

    // T4: abort at cycle 40
    for (int i = 0; i < 5; i++) write_entry(i, tv[i]);
    cyc_e = 0;
    push_pass(4, 40);
    pulse_start();
    run_stream("t4", 39);
    bus.abort = 1'b1;
    run_stream("t4", 1);
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_idle[%0d]", i), sample(), zero_o);
      step();
    end

    // T5: rewrite active entry 2 and start during RUN
    bus.loop_en = 1'b1;
    cyc_e = 0;
    push_pass(4, 1000);
    tbl_m[2].sw = 4'hF;
    push_pass(4, 34);
    pulse_start();
    run_stream("t5", 35);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd2;
    bus.wr_data = {1'b1, 4'hF, 4'h0, 16'd30};
    bus.start   = 1'b1;
    run_stream("t5", 1);
    bus.wr_en   = 1'b0;
    bus.start   = 1'b0;
    run_stream("t5", 89);
    do_abort("t5_abort");
    bus.loop_en = 1'b0;

    // T6: empty table after reset, then reset mid-run clears the table
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    step();
    pulse_start();
    check("t6_empty_done", sample(), mk(1'b0, 4'h0, 4'h0, 4'd0, 1'b0, 1'b1, 24'd0));
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6_empty_after[%0d]", i), sample(), zero_o);
    end
    write_entry(0, '{1'b1, 4'h3, 4'h2, 16'd50});
    pulse_start();
    check("t6_run_first", sample(), mk(1'b1, 4'h3, 4'h2, 4'd0, 1'b1, 1'b0, 24'd1));
    repeat (5) step();
    check("t6_run_mid", sample(), mk(1'b1, 4'h3, 4'h2, 4'd0, 1'b1, 1'b0, 24'd6));
    Reset = 1'b1;
    step();
    check("t6_reset_mid_run", sample(), zero_o);
    Reset = 1'b0;
    step();
    pulse_start();
    check("t6_table_cleared", sample(), mk(1'b0, 4'h0, 4'h0, 4'd0, 1'b0, 1'b1, 24'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
